// File: rtl/rca_mul_seq_pkg.sv
// ---------------------------------------------------------------------------
// rca_mul_seq_pkg
// Shared definitions for the sequential shift-add multiplier controller.
//   state_t        : FSM encoding (IDLE / ADD / DONE), also used on the
//                    debug state output
//   DEFAULT_WIDTH  : default operand width (matches the 32-bit adder)
//   bits_for()     : counter width helper that never returns zero
// ---------------------------------------------------------------------------
package rca_mul_seq_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // $clog2 yields 0 for n<=1.  A counter still needs one bit, or the
    // declaration collapses to a zero-width vector.
    function automatic int bits_for(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rca_mul_seq_if.sv
// ---------------------------------------------------------------------------
// rca_mul_seq_if
// Request/result bus between a requester (master) and the multiplier (slave).
//   start   : request, master -> slave
//   mcand   : multiplicand, master -> slave
//   mplier  : multiplier, master -> slave
//   busy    : operation in progress, slave -> master
//   done    : one-cycle completion pulse, slave -> master
//   hi, lo  : product upper/lower halves, slave -> master
//
// Handshake: start is a level request.  The slave accepts it only on a clock
// edge where it is idle; mcand/mplier are captured at that same edge and are
// ignored afterwards.  busy rises the cycle after acceptance and stays high
// through the done cycle.  done pulses for exactly one cycle, and hi/lo are
// valid from then on until the next accepted start.  A start that is still
// high while done is high is not taken until the following idle cycle.
// ---------------------------------------------------------------------------
interface rca_mul_seq_if
    import rca_mul_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, mcand, mplier,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, mcand, mplier,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/rca_mul_seq.sv
// ---------------------------------------------------------------------------
// rca_mul_seq
// Sequential unsigned shift-add multiplier.  It does not contain an adder:
// it time-shares an external WIDTH-bit ripple-carry adder, driving its A/B/cIn
// and sampling Sum/cOut once SETTLE cycles have passed in each iteration.
// WIDTH iterations produce the 2*WIDTH-bit product in {hi, lo}.
//
// Parameters
//   WIDTH    operand width, equal to the adder width
//   SETTLE   cycles the adder gets to settle per iteration (>= 1)
// Ports
//   clk        clock, rising edge
//   reset      asynchronous, active-high reset
//   bus        request/result bus (slave side)
//   add_a      adder operand A (running upper half of the product)
//   add_b      adder operand B (multiplicand or zero)
//   add_cin    adder carry-in, held at 0
//   add_sum    adder sum
//   add_cout   adder carry-out
//   dbg_state  current FSM state
// ---------------------------------------------------------------------------
module rca_mul_seq
    import rca_mul_seq_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             reset,
    rca_mul_seq_if.slave     bus,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout,
    output state_t           dbg_state
);

    localparam int ITER_W = bits_for(WIDTH);
    localparam int CNT_W  = bits_for(SETTLE + 1);

    localparam logic [ITER_W-1:0] ITER_LAST   = ITER_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE - 1);

    state_t             state;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [WIDTH-1:0]   mcand_r;
    logic [ITER_W-1:0]  iter;
    logic [CNT_W-1:0]   wait_cnt;
    logic               busy;
    logic               done;

    // Adder operands are only presented while iterating; outside ADD the
    // shared adder sees zeros so the ALU path is not disturbed by stale data.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state == ST_ADD) begin
            add_a = hi;
            add_b = lo[0] ? mcand_r : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            hi       <= '0;
            lo       <= '0;
            mcand_r  <= '0;
            iter     <= '0;
            wait_cnt <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (bus.start) begin
                        // lo starts as the multiplier and is shifted out one
                        // bit per iteration while product bits shift in.
                        hi       <= '0;
                        lo       <= bus.mplier;
                        mcand_r  <= bus.mcand;
                        iter     <= '0;
                        wait_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= ST_ADD;
                    end
                end

                ST_ADD: begin
                    if (wait_cnt == SETTLE_LAST) begin
                        // Carry-out becomes the new hi MSB, so the full
                        // WIDTH+1-bit partial sum survives the right shift.
                        {hi, lo} <= {add_cout, add_sum, lo[WIDTH-1:1]};
                        wait_cnt <= '0;
                        iter     <= iter + ITER_W'(1);
                        if (iter == ITER_LAST) begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end

                ST_DONE: begin
                    // start is deliberately not looked at here; a held start
                    // is picked up on the next IDLE cycle.
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy  = busy;
    assign bus.done  = done;
    assign bus.hi    = hi;
    assign bus.lo    = lo;
    assign dbg_state = state;

endmodule

// File: tb/tb_rca_mul_seq.sv
// ---------------------------------------------------------------------------
// tb_rca_mul_seq
// Two multiplier instances (SETTLE=1 and SETTLE=3), each with its own
// behavioural adder.  Vector table, random operands against a 64-bit product
// model, and hand sequences for held start, operand change and reset abort.
// ---------------------------------------------------------------------------
module tb_rca_mul_seq;
    import rca_mul_seq_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rca_mul_seq_if #(.WIDTH(W)) if1 ();
    rca_mul_seq_if #(.WIDTH(W)) if3 ();

    logic [W-1:0] a1_a, a1_b, a1_sum, a3_a, a3_b, a3_sum;
    logic         a1_cin, a1_cout, a3_cin, a3_cout;
    state_t       st1, st3;

    assign {a1_cout, a1_sum} = {1'b0, a1_a} + {1'b0, a1_b} + {{W{1'b0}}, a1_cin};
    assign {a3_cout, a3_sum} = {1'b0, a3_a} + {1'b0, a3_b} + {{W{1'b0}}, a3_cin};

    rca_mul_seq #(.WIDTH(W), .SETTLE(1)) u_dut1 (
        .clk(clk), .reset(reset), .bus(if1.slave),
        .add_a(a1_a), .add_b(a1_b), .add_cin(a1_cin),
        .add_sum(a1_sum), .add_cout(a1_cout), .dbg_state(st1)
    );

    rca_mul_seq #(.WIDTH(W), .SETTLE(3)) u_dut3 (
        .clk(clk), .reset(reset), .bus(if3.slave),
        .add_a(a3_a), .add_b(a3_b), .add_cin(a3_cin),
        .add_sum(a3_sum), .add_cout(a3_cout), .dbg_state(st3)
    );

    int total = 0;
    int bad   = 0;
    int pulses1 = 0;
    int pulses3 = 0;

    always @(negedge clk) begin
        if (if1.done) pulses1++;
        if (if3.done) pulses3++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input int s, input logic st, input logic [W-1:0] a, input logic [W-1:0] b);
        if (s == 3) begin
            if3.start = st; if3.mcand = a; if3.mplier = b;
        end else begin
            if1.start = st; if1.mcand = a; if1.mplier = b;
        end
    endtask

    // Issues one start at a negedge, waits (bounded) for done and returns the
    // product, the number of negedges from the accepting edge to done, and
    // adder-side error counts.  Also checks the cycle after done is idle.
    task automatic run_op(input int s, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] hi_o, output logic [W-1:0] lo_o,
                          output int lat, output int bsel_err, output int bnz, output int cin_err);
        logic d, bz, dn;
        logic [W-1:0] ab;
        lat = 0; bsel_err = 0; bnz = 0; cin_err = 0;
        hi_o = '0; lo_o = '0;
        drive(s, 1'b1, a, b);
        d = 1'b0;
        while (!d && lat < 2000) begin
            @(negedge clk);
            lat++;
            if (lat == 1) drive(s, 1'b0, a, b);
            bz = (s == 3) ? if3.busy : if1.busy;
            dn = (s == 3) ? if3.done : if1.done;
            ab = (s == 3) ? a3_b : a1_b;
            if (((s == 3) ? a3_cin : a1_cin) !== 1'b0) cin_err++;
            if (bz && !dn) begin
                if (ab !== '0 && ab !== a) bsel_err++;
                if (ab !== '0) bnz++;
            end
            d = dn;
        end
        hi_o = (s == 3) ? if3.hi : if1.hi;
        lo_o = (s == 3) ? if3.lo : if1.lo;
        @(negedge clk);
        check("busy_after_done", 64'((s == 3) ? if3.busy : if1.busy), 64'd0);
        check("done_one_cycle",  64'((s == 3) ? if3.done : if1.done), 64'd0);
        check("add_a_idle", 64'((s == 3) ? a3_a : a1_a), 64'd0);
        check("add_b_idle", 64'((s == 3) ? a3_b : a1_b), 64'd0);
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;

    vec_t vecs[4];

    initial begin
        logic [W-1:0] rhi, rlo, ra, rb;
        logic [63:0]  prod;
        int lat, bsel, bnz, cin, p0, cnt;

        drive(1, 1'b0, '0, '0);
        drive(3, 1'b0, '0, '0);

        vecs[0] = '{32'd42,         32'd58,         32'h0000_0000, 32'h0000_0984};
        vecs[1] = '{32'd105,        32'd21,         32'h0000_0000, 32'h0000_089D};
        vecs[2] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001};
        vecs[3] = '{32'h0000_0000,  32'h1234_5678,  32'h0000_0000, 32'h0000_0000};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(if1.busy), 64'd0);
        check("rst_done", 64'(if1.done), 64'd0);
        check("rst_hi",   64'(if1.hi),   64'd0);
        check("rst_lo",   64'(if1.lo),   64'd0);
        check("rst_state", 64'(st1), 64'(ST_IDLE));
        check("rst_state3", 64'(st3), 64'(ST_IDLE));
        reset = 1'b0;
        @(negedge clk);

        // Table vectors on the SETTLE=1 instance
        for (int i = 0; i < 4; i++) begin
            p0 = pulses1;
            run_op(1, vecs[i].a, vecs[i].b, rhi, rlo, lat, bsel, bnz, cin);
            check($sformatf("vec%0d_hi", i), 64'(rhi), 64'(vecs[i].hi));
            check($sformatf("vec%0d_lo", i), 64'(rlo), 64'(vecs[i].lo));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd33);
            check($sformatf("vec%0d_pulses", i), 64'(pulses1 - p0), 64'd1);
            check($sformatf("vec%0d_addb_sel", i), 64'(bsel), 64'd0);
            check($sformatf("vec%0d_cin", i), 64'(cin), 64'd0);
            if (vecs[i].a == '0) check("vec_zero_addb", 64'(bnz), 64'd0);
        end

        // Random operands against a plain 64-bit product
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 4 == 1) ra = W'($urandom_range(0, 255));
            if (i % 4 == 2) rb = {1'b1, W'($urandom) >> 1};
            prod = 64'(ra) * 64'(rb);
            p0 = pulses1;
            run_op(1, ra, rb, rhi, rlo, lat, bsel, bnz, cin);
            check($sformatf("rnd%0d_prod", i), {rhi, rlo}, prod);
            check($sformatf("rnd%0d_latency", i), 64'(lat), 64'd33);
            check($sformatf("rnd%0d_pulses", i), 64'(pulses1 - p0), 64'd1);
            check($sformatf("rnd%0d_addb_sel", i), 64'(bsel), 64'd0);
        end

        // Held start with operand change mid-operation
        p0 = pulses1;
        drive(1, 1'b1, 32'd7, 32'd9);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
            if (cnt == 10) drive(1, 1'b1, 32'd3, 32'd3);
        end while (!if1.done && cnt < 2000);
        check("held_latency", 64'(cnt), 64'd33);
        check("held_lo", 64'(if1.lo), 64'd63);
        check("held_hi", 64'(if1.hi), 64'd0);
        @(negedge clk);
        check("held_idle_busy", 64'(if1.busy), 64'd0);
        @(negedge clk);
        check("held_reaccept_busy", 64'(if1.busy), 64'd1);
        drive(1, 1'b0, 32'd3, 32'd3);
        cnt = 0;
        while (!if1.done && cnt < 2000) begin
            @(negedge clk);
            cnt++;
        end
        check("held_second_lo", 64'(if1.lo), 64'd9);
        check("held_second_latency", 64'(cnt), 64'd32);
        @(negedge clk);
        check("held_pulses", 64'(pulses1 - p0), 64'd2);

        // Reset in the middle of an operation
        p0 = pulses1;
        drive(1, 1'b1, 32'd6, 32'd7);
        @(negedge clk);
        drive(1, 1'b0, 32'd6, 32'd7);
        repeat (14) @(negedge clk);
        check("abort_was_busy", 64'(if1.busy), 64'd1);
        reset = 1'b1;
        #1;
        check("abort_busy", 64'(if1.busy), 64'd0);
        check("abort_done", 64'(if1.done), 64'd0);
        check("abort_hi",   64'(if1.hi),   64'd0);
        check("abort_lo",   64'(if1.lo),   64'd0);
        check("abort_state", 64'(st1), 64'(ST_IDLE));
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_no_pulse", 64'(pulses1 - p0), 64'd0);

        // SETTLE=3 instance
        p0 = pulses3;
        run_op(3, 32'd6, 32'd7, rhi, rlo, lat, bsel, bnz, cin);
        check("s3_lo", 64'(rlo), 64'd42);
        check("s3_hi", 64'(rhi), 64'd0);
        check("s3_latency", 64'(lat), 64'd97);
        check("s3_pulses", 64'(pulses3 - p0), 64'd1);
        for (int i = 0; i < 3; i++) begin
            ra = $urandom;
            rb = $urandom;
            prod = 64'(ra) * 64'(rb);
            run_op(3, ra, rb, rhi, rlo, lat, bsel, bnz, cin);
            check($sformatf("s3_rnd%0d_prod", i), {rhi, rlo}, prod);
            check($sformatf("s3_rnd%0d_latency", i), 64'(lat), 64'd97);
            check($sformatf("s3_rnd%0d_addb_sel", i), 64'(bsel), 64'd0);
        end
        p0 = pulses3;
        run_op(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, rhi, rlo, lat, bsel, bnz, cin);
        check("s3_max_prod", {rhi, rlo}, 64'hFFFF_FFFE_0000_0001);
        check("s3_max_pulses", 64'(pulses3 - p0), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
